// File: rtl/mio_bus_responder.sv
// mio_bus_responder
// Memory/IO bus responder for the multicycle CPU's single memory port.
// It takes one word access at a time and decodes it to on-chip RAM
// (0x0000_0000-0x0000_0FFF), the peripheral window (0xF000_0000-0xF000_00FF)
// or unmapped space. It adds per-region wait states and completes each access
// with a single-cycle MIO_ready pulse.
//
// Ports
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   mem_req, mem_w       : CPU access request (level) and write flag
//   M_addr, data_out     : CPU byte address (bits [1:0] ignored) and write data
//   data2CPU             : registered read data, valid with MIO_ready
//   MIO_ready, bus_err   : completion pulse and unmapped-access flag
//   ram_addr/we/wdata    : RAM word address, write strobe and write data
//   ram_rdata            : synchronous RAM read data
//   io_addr/we/re/wdata  : peripheral register index, write/read strobes and
//                          write data
//   io_rdata             : synchronous peripheral read data
module mio_bus_responder #(
  parameter int RAM_WAIT = 1,  // 1..15
  parameter int IO_WAIT  = 2   // 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_w,
  input  logic [31:0] M_addr,
  input  logic [31:0] data_out,
  output logic [31:0] data2CPU,
  output logic        MIO_ready,
  output logic        bus_err,
  output logic [9:0]  ram_addr,
  output logic        ram_we,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic [5:0]  io_addr,
  output logic        io_we,
  output logic        io_re,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RAM_WAIT = 2'd1,
    S_IO_WAIT  = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        first_q, first_d;    // high only in the first wait cycle
  logic        we_q, we_d;          // latched mem_w
  logic        err_q, err_d;        // current access is unmapped
  logic [9:0]  addr_q, addr_d;      // latched M_addr[11:2]
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic is_ram;
  logic is_io;
  logic unused_byte_offset;

  assign is_ram = (M_addr[31:12] == 20'h0_0000);
  assign is_io  = (M_addr[31:8] == 24'hF0_0000);

  // Word accesses only: the byte offset carries no information.
  assign unused_byte_offset = ^M_addr[1:0];

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      first_q <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 10'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = 1'b0;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          // Latch the whole request so later CPU bus changes cannot disturb it.
          addr_d  = M_addr[11:2];
          wdata_d = data_out;
          we_d    = mem_w;
          err_d   = 1'b0;
          if (is_ram) begin
            state_d = S_RAM_WAIT;
            cnt_d   = 4'(RAM_WAIT);
            first_d = 1'b1;
          end else if (is_io) begin
            state_d = S_IO_WAIT;
            cnt_d   = 4'(IO_WAIT);
            first_d = 1'b1;
          end else begin
            // Unmapped: complete at once with an error. Reads return zero.
            state_d = S_DONE;
            err_d   = 1'b1;
            if (!mem_w) begin
              rdata_d = 32'd0;
            end
          end
        end
      end

      S_RAM_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
          if (!we_q) begin
            rdata_d = ram_rdata;
          end
        end
      end

      S_IO_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
          if (!we_q) begin
            rdata_d = io_rdata;
          end
        end
      end

      S_DONE: begin
        // mem_req is ignored here; a still-high request is picked up in IDLE.
        state_d = S_IDLE;
        err_d   = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs. Strobes fire once per access, in the first wait cycle.
  always_comb begin
    ram_addr  = addr_q;
    io_addr   = addr_q[5:0];  // M_addr[7:2]
    ram_wdata = wdata_q;
    io_wdata  = wdata_q;
    data2CPU  = rdata_q;
    ram_we    = (state_q == S_RAM_WAIT) && first_q && we_q;
    io_we     = (state_q == S_IO_WAIT) && first_q && we_q;
    io_re     = (state_q == S_IO_WAIT) && first_q && !we_q;
    MIO_ready = (state_q == S_DONE);
    bus_err   = (state_q == S_DONE) && err_q;
  end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Bench for mio_bus_responder: transaction-level model plus directed vectors.
module tb_mio_bus_responder;

  localparam int RAM_W = 1;
  localparam int IO_W  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic        mem_w;
  logic [31:0] M_addr;
  logic [31:0] data_out;
  logic [31:0] data2CPU;
  logic        MIO_ready;
  logic        bus_err;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [5:0]  io_addr;
  logic        io_we;
  logic        io_re;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;

  mio_bus_responder #(.RAM_WAIT(RAM_W), .IO_WAIT(IO_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_w     (mem_w),
    .M_addr    (M_addr),
    .data_out  (data_out),
    .data2CPU  (data2CPU),
    .MIO_ready (MIO_ready),
    .bus_err   (bus_err),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .io_addr   (io_addr),
    .io_we     (io_we),
    .io_re     (io_re),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Transaction-level model. cyc is the index of the current clock interval;
  // an access accepted at the edge ending interval t completes (MIO_ready)
  // in interval t+latency, strobes in interval t+1, and the responder can
  // accept again at the edge ending interval t+latency+1.
  // ---------------------------------------------------------------------
  localparam int K_NONE = 0, K_RAM_WE = 1, K_IO_WE = 2, K_IO_RE = 3;

  int          cyc = 0;
  int          ready_cyc = -1;
  int          strobe_cyc = -1;
  int          strobe_kind = K_NONE;
  int          cap_edge = -1;
  int          cap_src = 0;          // 1 = RAM, 2 = IO
  int          idle_at = 0;
  int          txn_no = 0;
  bit          exp_err = 1'b0;
  bit          model_valid = 1'b0;
  logic [31:0] exp_addr = 32'd0;
  logic [31:0] exp_wdata = 32'd0;
  logic [31:0] exp_d2c = 32'd0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        ready_cyc   = -1;
        strobe_cyc  = -1;
        strobe_kind = K_NONE;
        cap_edge    = -1;
        exp_err     = 1'b0;
        exp_addr    = 32'd0;
        exp_wdata   = 32'd0;
        exp_d2c     = 32'd0;
        idle_at     = cyc + 1;
        model_valid = 1'b1;
      end else begin
        if (cyc == cap_edge) begin
          exp_d2c = (cap_src == 1) ? ram_rdata : io_rdata;
        end
        if (mem_req && cyc >= idle_at) begin
          int    lat;
          string region;
          exp_addr  = M_addr;
          exp_wdata = data_out;
          cap_edge  = -1;
          if (M_addr <= 32'h0000_0FFF) begin
            region      = "RAM";
            lat         = RAM_W + 1;
            exp_err     = 1'b0;
            strobe_kind = mem_w ? K_RAM_WE : K_NONE;
            if (!mem_w) begin
              cap_edge = cyc + lat - 1;
              cap_src  = 1;
            end
          end else if (M_addr >= 32'hF000_0000 && M_addr <= 32'hF000_00FF) begin
            region      = "IO";
            lat         = IO_W + 1;
            exp_err     = 1'b0;
            strobe_kind = mem_w ? K_IO_WE : K_IO_RE;
            if (!mem_w) begin
              cap_edge = cyc + lat - 1;
              cap_src  = 2;
            end
          end else begin
            region      = "unmapped";
            lat         = 1;
            exp_err     = 1'b1;
            strobe_kind = K_NONE;
            if (!mem_w) exp_d2c = 32'd0;
          end
          strobe_cyc = cyc + 1;
          ready_cyc  = cyc + lat;
          idle_at    = cyc + lat + 1;
          txn_no++;
          $display("txn %0d: %s %s addr=%h wdata=%h accepted in cycle %0d, ready expected in cycle %0d",
                   txn_no, mem_w ? "write" : "read", region, M_addr, data_out, cyc, ready_cyc);
        end
      end
      cyc++;
    end
  end

  // Compare process: every interval after the first reset edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        chk("MIO_ready", {31'd0, MIO_ready}, {31'd0, cyc == ready_cyc});
        chk("bus_err",   {31'd0, bus_err},   {31'd0, (cyc == ready_cyc) && exp_err});
        chk("ram_we",    {31'd0, ram_we},    {31'd0, (cyc == strobe_cyc) && (strobe_kind == K_RAM_WE)});
        chk("io_we",     {31'd0, io_we},     {31'd0, (cyc == strobe_cyc) && (strobe_kind == K_IO_WE)});
        chk("io_re",     {31'd0, io_re},     {31'd0, (cyc == strobe_cyc) && (strobe_kind == K_IO_RE)});
        chk("ram_addr",  {22'd0, ram_addr},  {22'd0, exp_addr[11:2]});
        chk("io_addr",   {26'd0, io_addr},   {26'd0, exp_addr[7:2]});
        chk("ram_wdata", ram_wdata, exp_wdata);
        chk("io_wdata",  io_wdata,  exp_wdata);
        chk("data2CPU",  data2CPU,  exp_d2c);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Directed stimulus. Inputs change on the falling edge.
  // ---------------------------------------------------------------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Returns at the falling edge of cycle 1 with mem_req dropped.
  task automatic start(input logic [31:0] a, input logic w, input logic [31:0] d);
    @(negedge clk);
    M_addr   = a;
    mem_w    = w;
    data_out = d;
    mem_req  = 1'b1;
    @(negedge clk);
    mem_req  = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    mem_req   = 1'b0;
    mem_w     = 1'b0;
    M_addr    = 32'd0;
    data_out  = 32'd0;
    ram_rdata = 32'd0;
    io_rdata  = 32'd0;
    idle(3);
    reset = 1'b0;
    idle(1);
    chk("lit reset MIO_ready", {31'd0, MIO_ready}, 32'd0);
    chk("lit reset data2CPU", data2CPU, 32'd0);
    chk("lit reset ram_addr", {22'd0, ram_addr}, 32'd0);

    // RAM read of word 5
    ram_rdata = 32'hDEAD_BEEF;
    start(32'h0000_0014, 1'b0, 32'h0);
    chk("lit ram rd addr c1", {22'd0, ram_addr}, 32'd5);
    chk("lit ram rd we c1", {31'd0, ram_we}, 32'd0);
    idle(1);
    chk("lit ram rd ready c2", {31'd0, MIO_ready}, 32'd1);
    chk("lit ram rd data c2", data2CPU, 32'hDEAD_BEEF);
    idle(2);

    // RAM write to the last word; bus changes after acceptance must not matter
    start(32'h0000_0FFC, 1'b1, 32'h1234_5678);
    M_addr   = 32'h0000_0040;
    data_out = 32'hFFFF_FFFF;
    chk("lit ram wr we c1", {31'd0, ram_we}, 32'd1);
    chk("lit ram wr addr c1", {22'd0, ram_addr}, 32'h3FF);
    chk("lit ram wr wdata c1", ram_wdata, 32'h1234_5678);
    idle(1);
    chk("lit ram wr ready c2", {31'd0, MIO_ready}, 32'd1);
    chk("lit ram wr we c2", {31'd0, ram_we}, 32'd0);
    chk("lit ram wr data2CPU", data2CPU, 32'hDEAD_BEEF);
    idle(2);

    // IO read of register 2
    io_rdata = 32'h0000_00A5;
    start(32'hF000_0008, 1'b0, 32'h0);
    chk("lit io rd addr c1", {26'd0, io_addr}, 32'd2);
    chk("lit io rd re c1", {31'd0, io_re}, 32'd1);
    idle(1);
    chk("lit io rd re c2", {31'd0, io_re}, 32'd0);
    chk("lit io rd ready c2", {31'd0, MIO_ready}, 32'd0);
    idle(1);
    chk("lit io rd ready c3", {31'd0, MIO_ready}, 32'd1);
    chk("lit io rd data c3", data2CPU, 32'h0000_00A5);
    idle(2);

    // IO write to the top register of the window
    start(32'hF000_00FC, 1'b1, 32'hCAFE_F00D);
    chk("lit io wr we c1", {31'd0, io_we}, 32'd1);
    chk("lit io wr addr c1", {26'd0, io_addr}, 32'h3F);
    idle(4);

    // Unmapped read, then unmapped write
    start(32'h1000_0000, 1'b0, 32'h0);
    chk("lit unm rd ready c1", {31'd0, MIO_ready}, 32'd1);
    chk("lit unm rd err c1", {31'd0, bus_err}, 32'd1);
    chk("lit unm rd data c1", data2CPU, 32'd0);
    idle(2);
    start(32'h1000_0000, 1'b1, 32'h5555_AAAA);
    chk("lit unm wr ready c1", {31'd0, MIO_ready}, 32'd1);
    chk("lit unm wr err c1", {31'd0, bus_err}, 32'd1);
    chk("lit unm wr strobes c1", {29'd0, ram_we, io_we, io_re}, 32'd0);
    idle(2);

    // Back-to-back RAM reads with mem_req held high
    @(negedge clk);                       // cycle 0
    M_addr    = 32'h0000_0020;
    mem_w     = 1'b0;
    mem_req   = 1'b1;
    ram_rdata = 32'h1111_1111;
    idle(2);                              // cycle 2
    chk("lit b2b ready c2", {31'd0, MIO_ready}, 32'd1);
    chk("lit b2b data c2", data2CPU, 32'h1111_1111);
    idle(1);                              // cycle 3: second acceptance
    chk("lit b2b ready c3", {31'd0, MIO_ready}, 32'd0);
    ram_rdata = 32'h2222_2222;
    idle(2);                              // cycle 5
    chk("lit b2b ready c5", {31'd0, MIO_ready}, 32'd1);
    chk("lit b2b data c5", data2CPU, 32'h2222_2222);
    mem_req = 1'b0;
    idle(2);

    // Reset during cycle 1 of an IO read
    io_rdata = 32'h0000_0077;
    start(32'hF000_0004, 1'b0, 32'h0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("lit rst ready", {31'd0, MIO_ready}, 32'd0);
    chk("lit rst data", data2CPU, 32'd0);
    chk("lit rst io_addr", {26'd0, io_addr}, 32'd0);
    chk("lit rst strobes", {29'd0, ram_we, io_we, io_re}, 32'd0);
    idle(1);
    chk("lit rst no ready c3", {31'd0, MIO_ready}, 32'd0);
    idle(2);

    // Responder is idle again after the abort
    ram_rdata = 32'h0BAD_CAFE;
    start(32'h0000_0100, 1'b0, 32'h0);
    idle(1);
    chk("lit post-rst ready", {31'd0, MIO_ready}, 32'd1);
    chk("lit post-rst data", data2CPU, 32'h0BAD_CAFE);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mio_bus_responder.md
# mio_bus_responder

Memory/IO bus responder serving the multicycle CPU's single memory port. It accepts one word access at a time from the CPU (address, write data, write strobe), decodes it to on-chip RAM, the peripheral window or unmapped space, inserts per-region wait states, and returns read data on `data2CPU` with a one-cycle `MIO_ready` pulse. It sits between the CPU data path and the RAM/peripheral blocks.

## Interface
- `RAM_WAIT`, 1, RAM wait-state cycles; legal range 1–15.
- `IO_WAIT`, 2, peripheral wait-state cycles; legal range 1–15.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_req`  in  1  CPU access request (level).
- `mem_w`  in  1  1 = write, 0 = read; qualified by `mem_req`.
- `M_addr`  in  32  CPU byte address; bits [1:0] ignored (word accesses only).
- `data_out`  in  32  CPU write data.
- `data2CPU`  out  32  read data returned to the CPU, registered.
- `MIO_ready`  out  1  transaction-complete pulse, exactly one cycle.
- `bus_err`  out  1  unmapped-access flag, high only with `MIO_ready`.
- `ram_addr`  out  10  RAM word address = `M_addr[11:2]`.
- `ram_we`  out  1  RAM write strobe.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM read data, synchronous (valid one cycle after `ram_addr`).
- `io_addr`  out  6  peripheral register index = `M_addr[7:2]`.
- `io_we`  out  1  peripheral write strobe.
- `io_re`  out  1  peripheral read strobe (for read side effects, e.g. FIFO pop).
- `io_wdata`  out  32  peripheral write data.
- `io_rdata`  in  32  peripheral read data, synchronous.

## Operation
- Address map: RAM = `0x0000_0000`–`0x0000_0FFF`; IO = `0xF000_0000`–`0xF000_00FF`; all other addresses are unmapped.
- States are IDLE, RAM_WAIT, IO_WAIT and DONE. A 4-bit wait counter is used.
- **IDLE:** when `mem_req=1`, latch `M_addr`, `data_out` and `mem_w` and decode the address.
  - RAM → RAM_WAIT, counter = `RAM_WAIT`.
  - IO → IO_WAIT, counter = `IO_WAIT`.
  - Unmapped → DONE with `bus_err` armed.
- **RAM_WAIT / IO_WAIT:**
  - `ram_addr`/`io_addr` and write data are driven from the latched registers and stay stable for the whole wait.
  - The write strobe (`ram_we`/`io_we`) fires only in the first wait cycle, and only for writes. For reads, `io_re` fires only in the first IO wait cycle.
  - The counter decrements each cycle. In the cycle it equals 1, capture `ram_rdata`/`io_rdata` into `data2CPU` (reads only) and go to DONE.
- **DONE:** `MIO_ready=1` for one cycle; `bus_err=1` if the access was unmapped. `mem_req` is ignored. Next state is IDLE.
- Writes never modify `data2CPU`. Unmapped reads load `data2CPU` with `0x0000_0000`. Unmapped writes produce no strobe.
- `data2CPU` holds its value until the next read completes.
- CPU rule: `mem_req` must be low in the cycle after `MIO_ready` unless a new access is intended. A high level in IDLE always starts a new transaction, so back-to-back accesses are legal.

## Timing
- Reset values: `MIO_ready=0`, `bus_err=0`, `data2CPU=0`, `ram_we=0`, `io_we=0`, `io_re=0`, `ram_addr=0`, `io_addr=0`, `ram_wdata=0`, `io_wdata=0`; state = IDLE.
- Let cycle 0 be the IDLE cycle that samples `mem_req=1`.
  - RAM: `MIO_ready` in cycle `RAM_WAIT+1` (cycle 2 at default).
  - IO: `MIO_ready` in cycle `IO_WAIT+1` (cycle 3 at default).
  - Unmapped: `MIO_ready` in cycle 1.
- Strobes occur in cycle 1 only, at most one per transaction.
- `data2CPU` is valid in the same cycle as `MIO_ready`.
- Minimum spacing between acceptances is latency + 1 cycles.
- Reset asserted mid-transaction aborts it: no `MIO_ready`, no further strobes, outputs take reset values on the next edge.
- An `M_addr`/`data_out` change after acceptance has no effect on the current transaction.

## Test plan
- Reset, then read RAM word 5 (`M_addr=0x14`) with `ram_rdata=0xDEADBEEF` → `ram_addr=5` from cycle 1; `MIO_ready` and `data2CPU=0xDEADBEEF` in cycle 2; `ram_we` never high.
- Write `0x12345678` to `0x0000_0FFC` → `ram_we=1` in cycle 1 only with `ram_addr=0x3FF` and `ram_wdata=0x12345678`; `MIO_ready` in cycle 2; `data2CPU` unchanged.
- Read `0xF000_0008` with `io_rdata=0xA5` → `io_addr=2`, `io_re` pulses in cycle 1 only, `MIO_ready` with `data2CPU=0xA5` in cycle 3.
- Read `0x1000_0000` → `MIO_ready=1` and `bus_err=1` in cycle 1, `data2CPU=0`, no strobes; a write to the same address gives the same flags with no strobes.
- Back-to-back: `mem_req` held high across a RAM read → second transaction accepted in the cycle after `MIO_ready`; `MIO_ready` pulses again 3 cycles later.
- Assert `reset` in cycle 1 of an IO read → no `MIO_ready`; all outputs return to reset values; state = IDLE.
